// File: rtl/trng_conditioner.sv
// Conditions the raw TRNG bit for the fractional-N dither path: paced sampling,
// repetition-count health test, von Neumann debiasing and word packing.
module trng_conditioner #(
  parameter int WORD_W     = 8,
  parameter int SAMPLE_DIV = 4,
  parameter int WARMUP     = 16,
  parameter int REP_LIMIT  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              random_in,
  output logic              trng_stop,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              fault
);

  localparam int CNT_W   = $clog2(WORD_W + 1);
  localparam int PRESC_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(WORD_W);
  localparam logic [7:0]         REP_TRIP   = 8'(REP_LIMIT);
  localparam logic [8:0]         WARM_LAST  = 9'(WARMUP);

  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_RUN, S_FAULT} state_t;

  state_t              r_state, w_state_nxt;
  logic [PRESC_W-1:0]  r_presc;
  logic [7:0]          r_warm;
  logic [7:0]          r_rep;
  logic                r_prev;
  logic                r_pair_have;
  logic                r_pair_bit;
  logic [WORD_W-1:0]   r_acc;
  logic [CNT_W-1:0]    r_acc_cnt;
  logic [WORD_W-1:0]   r_out_data;
  logic                r_out_valid;

  logic                w_active;
  logic                w_full;
  logic                w_strobe;
  logic [7:0]          w_rep_nxt;
  logic                w_trip;
  logic                w_warm_done;
  logic                w_load;

  assign w_active    = (r_state == S_WARMUP) || (r_state == S_RUN);
  assign w_full      = (r_acc_cnt == CNT_FULL);
  // A full accumulator freezes sampling entirely, including the health test.
  assign w_strobe    = w_active && enable && !w_full && (r_presc == PRESC_LAST);
  assign w_rep_nxt   = (r_rep == 8'd0)          ? 8'd1 :
                       (random_in == r_prev)    ? r_rep + 8'd1 : 8'd1;
  assign w_trip      = w_strobe && (w_rep_nxt == REP_TRIP);
  assign w_warm_done = (r_state == S_WARMUP) && w_strobe &&
                       (({1'b0, r_warm} + 9'd1) == WARM_LAST);
  assign w_load      = (r_state == S_RUN) && enable && w_full &&
                       (!r_out_valid || out_ready);

  assign trng_stop = w_active;
  assign fault     = (r_state == S_FAULT);
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (enable) w_state_nxt = (WARMUP == 0) ? S_RUN : S_WARMUP;
      S_WARMUP: if (!enable)        w_state_nxt = S_IDLE;
                else if (w_trip)    w_state_nxt = S_FAULT;
                else if (w_warm_done) w_state_nxt = S_RUN;
      S_RUN:    if (!enable)        w_state_nxt = S_IDLE;
                else if (w_trip)    w_state_nxt = S_FAULT;
      S_FAULT:  if (!enable)        w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_presc     <= '0;
      r_warm      <= '0;
      r_rep       <= '0;
      r_prev      <= 1'b0;
      r_pair_have <= 1'b0;
      r_pair_bit  <= 1'b0;
      r_acc       <= '0;
      r_acc_cnt   <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (!w_active || !enable)  r_presc <= '0;
      else if (w_strobe)         r_presc <= '0;
      else if (!w_full)          r_presc <= r_presc + 1'b1;

      if (!w_active || !enable)                   r_warm <= '0;
      else if (w_strobe && r_state == S_WARMUP)   r_warm <= r_warm + 8'd1;

      if (r_state == S_IDLE || !enable) begin
        r_rep <= '0;
      end else if (w_strobe) begin
        r_rep  <= w_rep_nxt;
        r_prev <= random_in;
      end

      if (!enable || r_state != S_RUN || w_trip) begin
        r_acc       <= '0;
        r_acc_cnt   <= '0;
        r_pair_have <= 1'b0;
      end else if (w_load) begin
        r_acc     <= '0;
        r_acc_cnt <= '0;
      end else if (w_strobe) begin
        if (!r_pair_have) begin
          r_pair_bit  <= random_in;
          r_pair_have <= 1'b1;
        end else begin
          r_pair_have <= 1'b0;
          // Unequal pair emits its first sample: 1,0 -> 1 and 0,1 -> 0.
          if (r_pair_bit != random_in) begin
            r_acc     <= {r_pair_bit, r_acc[WORD_W-1:1]};
            r_acc_cnt <= r_acc_cnt + 1'b1;
          end
        end
      end

      if (!enable && r_state != S_IDLE) begin
        r_out_valid <= 1'b0;
      end else if (w_trip || r_state == S_FAULT) begin
        r_out_valid <= 1'b0;
      end else if (w_load) begin
        r_out_data  <= r_acc;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_trng_conditioner.sv
// Directed bench for trng_conditioner: expected words go to a scoreboard queue
// and are compared on each handshake; control outputs are checked inline.
module tb_trng_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       random_in;
  logic       out_ready;
  logic       trng_stop;
  logic       out_valid;
  logic       fault;
  logic [7:0] out_data;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] sb_q[$];
  logic [7:0] sb_exp;

  trng_conditioner #(
    .WORD_W(8), .SAMPLE_DIV(1), .WARMUP(2), .REP_LIMIT(4)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .random_in(random_in),
    .trng_stop(trng_stop), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic b);
    random_in = b;
    @(posedge clk);
    #1;
  endtask

  // Fresh enable, two warm-up samples, n RUN samples, then the load and handshake.
  task automatic run_word(input string tag, input logic [1:0] warm,
                          input logic [31:0] pat, input int n, input logic [7:0] exp);
    enable = 1'b0; out_ready = 1'b1; tick(1'b0);
    sb_q.push_back(exp);
    enable = 1'b1; tick(1'b0);
    tick(warm[0]); tick(warm[1]);
    for (int i = 0; i < n; i++) tick(pat[i]);
    check({tag, "_pre"}, out_valid, 0);
    tick(~pat[n-1]);
    check({tag, "_rise"}, out_valid, 1);
    tick(~pat[n-1]);
    check({tag, "_ack"}, out_valid, 0);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb_q.size() > 0) begin
        sb_exp = sb_q.pop_front();
        check("sb_word", out_data, sb_exp);
      end else begin
        checks++;
        errors++;
        $error("FAIL sb_unexpected: observed=%0h expected=no word", out_data);
      end
    end
  end

  initial begin
    rst = 1'b0; enable = 1'b1; random_in = 1'b1; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stop",  trng_stop, 0);
    check("rst_valid", out_valid, 0);
    check("rst_fault", fault, 0);
    check("rst_data",  out_data, 0);
    rst = 1'b1;
    tick(1'b1);
    check("rel_stop", trng_stop, 1);

    run_word("ones",  2'b10, 32'h5555_5555, 16, 8'hFF);
    run_word("zeros", 2'b01, 32'hAAAA_AAAA, 16, 8'h00);
    run_word("alt",   2'b10, 32'h9999_9999, 16, 8'h55);
    run_word("disc",  2'b10, 32'hB4B4_B4B4, 32, 8'h55);

    // Backpressure: two words while the consumer stalls.
    enable = 1'b0; out_ready = 1'b0; tick(1'b0);
    sb_q.push_back(8'hFF);
    sb_q.push_back(8'h00);
    enable = 1'b1; tick(1'b0); tick(1'b0); tick(1'b1);
    for (int i = 0; i < 16; i++) tick(i % 2 == 0);
    tick(1'b1);
    check("bp_valid1", out_valid, 1);
    check("bp_data1",  out_data, 8'hFF);
    for (int i = 0; i < 16; i++) tick(i % 2 != 0);
    check("bp_hold_valid", out_valid, 1);
    check("bp_hold_data",  out_data, 8'hFF);
    for (int i = 0; i < 8; i++) tick(1'b1);
    check("bp_frozen_fault", fault, 0);
    check("bp_frozen_data",  out_data, 8'hFF);
    check("bp_frozen_stop",  trng_stop, 1);
    out_ready = 1'b1; tick(1'b0); out_ready = 1'b0;
    check("bp_valid2", out_valid, 1);
    check("bp_data2",  out_data, 8'h00);
    out_ready = 1'b1; tick(1'b0);
    check("bp_ack", out_valid, 0);

    // Stuck-at-1 source trips the repetition test on the 4th sample.
    enable = 1'b0; tick(1'b1);
    enable = 1'b1; tick(1'b1);
    tick(1'b1); tick(1'b1); tick(1'b1);
    check("flt_pre_fault", fault, 0);
    check("flt_pre_stop",  trng_stop, 1);
    tick(1'b1);
    check("flt_fault", fault, 1);
    check("flt_stop",  trng_stop, 0);
    check("flt_valid", out_valid, 0);
    tick(1'b1);
    check("flt_sticky", fault, 1);
    enable = 1'b0; tick(1'b0);
    check("flt_clear", fault, 0);
    check("flt_idle_stop", trng_stop, 0);
    enable = 1'b1; tick(1'b0);
    check("flt_restart_stop", trng_stop, 1);
    run_word("post_flt", 2'b01, 32'hAAAA_AAAA, 16, 8'h00);

    // Abort after three accepted 1-bits; the next word must hold none of them.
    enable = 1'b0; tick(1'b0);
    enable = 1'b1; tick(1'b0); tick(1'b0); tick(1'b1);
    for (int i = 0; i < 6; i++) tick(i % 2 == 0);
    check("abort_valid", out_valid, 0);
    enable = 1'b0; tick(1'b0);
    check("abort_idle_stop", trng_stop, 0);
    run_word("abort", 2'b10, 32'hAAAA_AAAA, 16, 8'h00);

    check("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
